fifo_rd_port: RTL
=================

# fifo_rd_port

Read-side controller for the synchronous FIFO. It drives the read address of the two-port RAM, whose read is combinational (zero-clock), and consumes the write pointer published by the write-side controller. It presents the data through a registered valid/ready output stage and returns its read pointer to the write side for full detection.

## Interface
- DW, 18, data width; must match the RAM.
- AW, 7, RAM address width; depth is 2**AW.
- clk  in  1  clock; all logic is on the rising edge.
- rst_n  in  1  synchronous, active-low reset.
- wr_ptr  in  AW+1  write pointer from the write side, with a wrap bit; only ever increments by 0 or 1 per cycle.
- rd_addr  out  AW  RAM read address; equals rd_ptr[AW-1:0] combinationally.
- rd_data  in  DW  RAM read data; combinational from rd_addr.
- rd_ptr  out  AW+1  read pointer with wrap bit, returned to the write side.
- out_valid  out  1  out_data holds a FIFO entry.
- out_ready  in  1  downstream accepts out_data when out_valid=1.
- out_data  out  DW  registered FIFO head.
- level  out  AW+1  RAM entries not yet loaded: wr_ptr-rd_ptr, modulo 2**(AW+1).
- empty  out  1  level==0 and out_valid==0.
- err  out  1  sticky flag; set when level>2**AW (write side overran).
- flush  in  1  present only with FIFO_RD_FLUSH_EN.

## Operation
- Output stage FSM, two states:
  - IDLE (out_valid=0): if ram_nonempty, load out_data<=rd_data, rd_ptr++, go to HOLD.
  - HOLD (out_valid=1): on out_ready, if ram_nonempty reload (rd_ptr++) and stay in HOLD; otherwise go to IDLE. Without out_ready, hold out_data and rd_ptr unchanged.
- ram_nonempty = (wr_ptr != rd_ptr).
- pop = ram_nonempty & (!out_valid | out_ready). This is the only condition that increments rd_ptr.
- Pointer arithmetic is AW+1 bits and wraps modulo 2**(AW+1). Address wrap 2**AW-1→0 is seamless.
- level is unsigned AW+1-bit subtraction. A value >2**AW sets err at the next edge. err clears only on reset. Popping continues while err=1; the data is undefined.
- out_data never changes while out_valid=1 and out_ready=0.
- Simultaneous write and pop in the same cycle: both pointers advance and level is unchanged.

## Timing
- Reset (rst_n=0 at an edge): rd_ptr=0, out_valid=0, out_data=0, err=0. Consequently rd_addr=0, level=wr_ptr (the write side resets to 0 in the same cycle, so level=0), empty=1.
- A reset mid-operation discards the held entry and any RAM contents. The write side must be reset in the same cycle.
- Latency: wr_ptr increments at edge N → out_valid=1 after edge N+1.
- Throughput: one entry per cycle while out_ready=1 and the RAM stays non-empty.
- level, empty, and rd_addr are combinational from registers and wr_ptr; there is no combinational path from out_ready to any output.
- pop depends combinationally on out_ready and wr_ptr.

## Configuration
- FIFO_RD_FLUSH_EN defined:
  - Adds the flush input.
  - flush=1 at an edge sets rd_ptr<=wr_ptr (the sampled value) and out_valid<=0, and suppresses pop in that cycle. out_data is not cleared.
  - A write occurring in the same cycle as flush is discarded, because the new wr_ptr value is not sampled.
  - err is unaffected.
  - rst_n has priority over flush.
- Undefined: no flush port; the block behaves exactly as described above.

## Test plan
- Reset, then write 1 entry (0x2A5) at edge 5 → out_valid=1 after edge 6 with out_data=0x2A5, level=0, empty=0. Pulse out_ready → empty=1.
- Write 10 entries back-to-back with out_ready=1 constant → 10 consecutive out_valid cycles, data in order, rd_ptr=10.
- Fill 2**AW=128 entries with out_ready=0 → level=127 (one entry held in the output stage), out_data held stable. Drain 128 entries with pointer wrap → order preserved, rd_ptr=128.
- Stall: out_valid=1, out_ready=0 for 20 cycles while writes continue → out_data and rd_ptr unchanged; release out_ready → every entry delivered once.
- Force wr_ptr-rd_ptr=129 → err=1 at the next edge and sticky; rst_n low → err=0.
- FIFO_RD_FLUSH_EN: hold 5 entries, assert flush → next cycle out_valid=0, level=0, rd_ptr=wr_ptr. A subsequent write appears after 1 cycle.

Source files
------------

// File: rtl/fifo_rd_port.sv
// Read-side controller for the synchronous FIFO: drives the RAM read address and registers the FIFO head.
// Latency: an entry whose write lands at edge N is presented (out_valid=1) after edge N+1.
// Backpressure: out_data/rd_ptr hold while out_valid=1 and out_ready=0. Optional flush via FIFO_RD_FLUSH_EN.
module fifo_rd_port #(
  parameter int DW = 18,
  parameter int AW = 7
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [AW:0]   wr_ptr,
  output logic [AW-1:0] rd_addr,
  input  logic [DW-1:0] rd_data,
  output logic [AW:0]   rd_ptr,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] out_data,
  output logic [AW:0]   level,
  output logic          empty,
  output logic          err
`ifdef FIFO_RD_FLUSH_EN
  ,
  input  logic          flush
`endif
);

  // Capacity of the RAM; any level above it means the write side overran us.
  localparam logic [AW:0] DEPTH = {1'b1, {AW{1'b0}}};

  typedef enum logic {
    IDLE = 1'b0,
    HOLD = 1'b1
  } state_t;

  state_t state;
  logic   ram_nonempty;
  logic   pop;
  logic   flush_i;

`ifdef FIFO_RD_FLUSH_EN
  assign flush_i = flush;
`else
  assign flush_i = 1'b0;
`endif

  // RAM occupancy and load decision; level only counts entries still in the RAM.
  assign ram_nonempty = (wr_ptr != rd_ptr);
  assign pop          = ram_nonempty & (~out_valid | out_ready) & ~flush_i;
  assign level        = wr_ptr - rd_ptr;
  assign empty        = (level == '0) && !out_valid;
  assign rd_addr      = rd_ptr[AW-1:0];

  // Output-stage FSM: load the head from the RAM whenever the stage is free or being drained.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      out_valid <= 1'b0;
      out_data  <= '0;
      rd_ptr    <= '0;
    end else if (flush_i) begin
      // Drop everything visible at this edge; a write landing this same edge is lost.
      state     <= IDLE;
      out_valid <= 1'b0;
      rd_ptr    <= wr_ptr;
    end else begin
      case (state)
        IDLE: begin
          if (pop) begin
            out_data  <= rd_data;
            rd_ptr    <= rd_ptr + 1'b1;
            out_valid <= 1'b1;
            state     <= HOLD;
          end
        end
        HOLD: begin
          if (out_ready) begin
            if (pop) begin
              out_data <= rd_data;
              rd_ptr   <= rd_ptr + 1'b1;
            end else begin
              out_valid <= 1'b0;
              state     <= IDLE;
            end
          end
        end
        default: begin
          out_valid <= 1'b0;
          state     <= IDLE;
        end
      endcase
    end
  end

  // Sticky overrun flag; only a reset clears it.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      err <= 1'b0;
    end else if (level > DEPTH) begin
      err <= 1'b1;
    end
  end

endmodule
